// File: rtl/horse_lights_monitor_if.sv
// Lamp-bus bundle between the light generator (master) and the loopback monitor (slave).
interface horse_lights_monitor_if;
  logic [7:0] led;
  logic       led_vld;
  logic [1:0] mode_det;
  logic       locked;
  logic [3:0] step_idx;
  logic [1:0] rep_cnt;
  logic       done;
  logic       err;

  modport master (
    output led, led_vld,
    input  mode_det, locked, step_idx, rep_cnt, done, err
  );

  modport slave (
    input  led, led_vld,
    output mode_det, locked, step_idx, rep_cnt, done, err
  );
endinterface

// File: rtl/horse_lights_monitor.sv
// Running-light receive checker: matches strobed lamp samples against the four mode sequences.
// Optional strobe-gap timeout is compiled in with `define HL_MON_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no candidate mode; waiting for a step-0 value
// S_TRACK | one or more candidate modes still match; following the steps
// S_HOLD  | REPS repetitions seen; outputs frozen until the next strobe
module horse_lights_monitor #(
  parameter int unsigned REPS        = 2,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic                   clk,
  input logic                   reset_n,
  horse_lights_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  function automatic logic [7:0] ref_val(input logic [1:0] mode, input logic [3:0] idx);
    logic [7:0] v;
    v = 8'h00;
    unique case (mode)
      2'd0: begin
        case (idx)
          4'd0:    v = 8'h80;
          4'd1:    v = 8'hC0;
          4'd2:    v = 8'hE0;
          4'd3:    v = 8'hF0;
          4'd4:    v = 8'hF8;
          4'd5:    v = 8'hFC;
          4'd6:    v = 8'hFE;
          4'd7:    v = 8'hFF;
          4'd8:    v = 8'h7F;
          4'd9:    v = 8'h3F;
          4'd10:   v = 8'h1F;
          4'd11:   v = 8'h0F;
          4'd12:   v = 8'h07;
          4'd13:   v = 8'h03;
          4'd14:   v = 8'h01;
          default: v = 8'h00;
        endcase
      end
      2'd1: begin
        case (idx)
          4'd0:    v = 8'h81;
          4'd1:    v = 8'hC3;
          4'd2:    v = 8'hE7;
          4'd3:    v = 8'hFF;
          4'd4:    v = 8'h7E;
          4'd5:    v = 8'h3C;
          4'd6:    v = 8'h18;
          default: v = 8'h00;
        endcase
      end
      2'd2: begin
        case (idx)
          4'd0:    v = 8'h80;
          4'd1:    v = 8'hC0;
          4'd2:    v = 8'hE0;
          default: v = 8'hF0;
        endcase
      end
      default: begin
        case (idx)
          4'd0:    v = 8'h87;
          4'd1:    v = 8'hC3;
          4'd2:    v = 8'hE1;
          4'd3:    v = 8'hF0;
          4'd4:    v = 8'h78;
          4'd5:    v = 8'h3C;
          4'd6:    v = 8'h1E;
          default: v = 8'h0F;
        endcase
      end
    endcase
    return v;
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] mode);
    return (mode == 2'd0) ? 4'd15 : 4'd7;
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] onehot);
    logic [1:0] m;
    m = 2'd0;
    case (onehot)
      4'b0010: m = 2'd1;
      4'b0100: m = 2'd2;
      4'b1000: m = 2'd3;
      default: m = 2'd0;
    endcase
    return m;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] exp_idx_q, exp_idx_d;
  logic [3:0] step_idx_q, step_idx_d;
  logic [1:0] rep_cnt_q, rep_cnt_d;
  logic [1:0] mode_det_q, mode_det_d;
  logic       locked_q, locked_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [3:0] step0_hit;
  logic [3:0] keep;
  logic [1:0] rep_inc;
  logic       restart;
  logic       timeout;

  // Step-0 hits and surviving candidates are evaluated for every mode in parallel.
  always_comb begin
    step0_hit = 4'b0000;
    keep      = 4'b0000;
    for (int m = 0; m < 4; m++) begin
      step0_hit[m] = (ref_val(2'(m), 4'd0) == bus.led);
      keep[m]      = cand_q[m] && (exp_idx_q <= last_idx(2'(m))) &&
                     (ref_val(2'(m), exp_idx_q) == bus.led);
    end
  end

  assign rep_inc = rep_cnt_q + 2'd1;

`ifdef HL_MON_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);

  logic [GAP_W-1:0] gap_q, gap_d;

  // Down-counter reloaded on every strobe; terminal count only matters while tracking.
  always_comb begin
    gap_d   = gap_q;
    timeout = 1'b0;
    if (bus.led_vld) begin
      gap_d = GAP_W'(TIMEOUT_CYC);
    end else if (state_q == S_TRACK) begin
      if (gap_q <= GAP_W'(1)) begin
        timeout = 1'b1;
      end else begin
        gap_d = gap_q - GAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_q <= GAP_W'(TIMEOUT_CYC);
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    exp_idx_d  = exp_idx_q;
    step_idx_d = step_idx_q;
    rep_cnt_d  = rep_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    restart    = 1'b0;

    if (bus.led_vld) begin
      unique case (state_q)
        S_IDLE: restart = 1'b1;
        S_HOLD: begin
          restart   = 1'b1;
          rep_cnt_d = 2'd0;
        end
        S_TRACK: begin
          if (keep == 4'b0000) begin
            err_d     = 1'b1;
            rep_cnt_d = 2'd0;
            restart   = 1'b1;
          end else begin
            cand_d = keep;
            if ($onehot(keep) && (exp_idx_q == last_idx(enc(keep)))) begin
              rep_cnt_d  = rep_inc;
              step_idx_d = 4'd0;
              exp_idx_d  = 4'd0;
              if (rep_inc == 2'(REPS)) begin
                done_d  = 1'b1;
                state_d = S_HOLD;
              end
            end else begin
              step_idx_d = exp_idx_q;
              exp_idx_d  = exp_idx_q + 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      err_d      = 1'b1;
      state_d    = S_IDLE;
      cand_d     = 4'b0000;
      rep_cnt_d  = 2'd0;
      step_idx_d = 4'd0;
      exp_idx_d  = 4'd0;
    end

    // The current sample doubles as step 0 of a fresh match (also after a violation).
    if (restart) begin
      cand_d     = step0_hit;
      step_idx_d = 4'd0;
      exp_idx_d  = 4'd1;
      state_d    = (step0_hit != 4'b0000) ? S_TRACK : S_IDLE;
    end

    locked_d   = $onehot(cand_d);
    mode_det_d = $onehot(cand_d) ? enc(cand_d) : 2'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cand_q     <= 4'b0000;
      exp_idx_q  <= 4'd0;
      step_idx_q <= 4'd0;
      rep_cnt_q  <= 2'd0;
      mode_det_q <= 2'd0;
      locked_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      exp_idx_q  <= exp_idx_d;
      step_idx_q <= step_idx_d;
      rep_cnt_q  <= rep_cnt_d;
      mode_det_q <= mode_det_d;
      locked_q   <= locked_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.mode_det = mode_det_q;
  assign bus.locked   = locked_q;
  assign bus.step_idx = step_idx_q;
  assign bus.rep_cnt  = rep_cnt_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_horse_lights_monitor.sv
// Scoreboard bench for horse_lights_monitor: directed scenarios plus random lamp traffic.
module tb_horse_lights_monitor;

  localparam int REPS = 2;

  typedef struct packed {
    logic [1:0] mdet;
    logic       locked;
    logic [3:0] idx;
    logic [1:0] reps;
    logic       done;
    logic       err;
  } obs_t;

  logic clk;
  logic reset_n;
  horse_lights_monitor_if bus ();

  horse_lights_monitor #(.REPS(REPS), .TIMEOUT_CYC(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] seqs [4][16] = '{
    '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
      8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00},
    '{8'h81, 8'hC3, 8'hE7, 8'hFF, 8'h7E, 8'h3C, 8'h18, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h87, 8'hC3, 8'hE1, 8'hF0, 8'h78, 8'h3C, 8'h1E, 8'h0F,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
  };
  int lens [4] = '{16, 8, 8, 8};

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t sb [$];
  obs_t hold_exp;
  bit   chk_quiet = 1'b1;

  // Reference model: list of modes still consistent with the samples seen.
  int m_cands [$];
  int m_nxt, m_idx, m_reps;
  bit m_hold;

  function automatic void model_clear();
    m_cands.delete();
    m_nxt = 0; m_idx = 0; m_reps = 0; m_hold = 1'b0;
  endfunction

  function automatic void model_restart(input logic [7:0] v);
    m_cands.delete();
    for (int m = 0; m < 4; m++) if (seqs[m][0] == v) m_cands.push_back(m);
    m_idx = 0;
    m_nxt = 1;
  endfunction

  function automatic obs_t model_step(input logic [7:0] v);
    obs_t o;
    int   keep [$];
    o = '0;
    if (m_cands.size() == 0 || m_hold) begin
      m_hold = 1'b0;
      m_reps = 0;
      model_restart(v);
    end else begin
      foreach (m_cands[i])
        if (m_nxt < lens[m_cands[i]] && seqs[m_cands[i]][m_nxt] == v) keep.push_back(m_cands[i]);
      if (keep.size() == 0) begin
        o.err  = 1'b1;
        m_reps = 0;
        model_restart(v);
      end else begin
        m_cands = keep;
        if (keep.size() == 1 && m_nxt == lens[keep[0]] - 1) begin
          m_reps++;
          m_idx = 0;
          m_nxt = 0;
          if (m_reps == REPS) begin
            o.done = 1'b1;
            m_hold = 1'b1;
          end
        end else begin
          m_idx = m_nxt;
          m_nxt++;
        end
      end
    end
    o.locked = (m_cands.size() == 1);
    o.mdet   = o.locked ? 2'(m_cands[0]) : 2'd0;
    o.idx    = 4'(m_idx);
    o.reps   = 2'(m_reps);
    return o;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic void cmp_obs(input string name, input obs_t got, input obs_t want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got mdet=%0d locked=%0d idx=%0d reps=%0d done=%0d err=%0d want mdet=%0d locked=%0d idx=%0d reps=%0d done=%0d err=%0d at %0t",
               name, got.mdet, got.locked, got.idx, got.reps, got.done, got.err,
               want.mdet, want.locked, want.idx, want.reps, want.done, want.err, $time);
    end
  endfunction

  // Monitor: every sampled strobe pops one expectation; quiet cycles must hold the last one.
  initial begin
    hold_exp = '0;
    forever begin
      logic strobe_seen;
      obs_t got, want;
      @(posedge clk);
      strobe_seen = bus.led_vld && reset_n;
      #1;
      got = {bus.mode_det, bus.locked, bus.step_idx, bus.rep_cnt, bus.done, bus.err};
      if (!reset_n) begin
        hold_exp = '0;
      end else if (strobe_seen) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: got strobe with empty scoreboard at %0t", $time);
        end else begin
          want = sb.pop_front();
          cmp_obs("strobe_out", got, want);
          hold_exp = want;
          hold_exp.done = 1'b0;
          hold_exp.err  = 1'b0;
        end
      end else if (chk_quiet) begin
        cmp_obs("quiet_hold", got, hold_exp);
      end
    end
  end

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    bus.led     = v;
    bus.led_vld = 1'b1;
    sb.push_back(model_step(v));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.led_vld = 1'b0;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mode_det"}, bus.mode_det, 0);
    chk({tag, "_locked"},   bus.locked,   0);
    chk({tag, "_step_idx"}, bus.step_idx, 0);
    chk({tag, "_rep_cnt"},  bus.rep_cnt,  0);
    chk({tag, "_done"},     bus.done,     0);
    chk({tag, "_err"},      bus.err,      0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.led_vld = 1'b0;
    reset_n     = 1'b0;
    #1;
    check_zero("rst_async");
    sb.delete();
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int         cur_mode, cur_pos, r;
    logic [7:0] v;

    bus.led     = 8'h00;
    bus.led_vld = 1'b0;
    reset_n     = 1'b1;
    model_clear();
    #2 reset_n  = 1'b0;
    #1 check_zero("rst_init");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Mode 0, two repetitions
    for (int rep = 0; rep < 2; rep++) begin
      for (int p = 0; p < 16; p++) begin
        drive(seqs[0][p]);
        if (rep == 0 && p == 3) begin
          settle(); chk("m0_unlocked_step3", bus.locked, 0);
        end
        if (rep == 0 && p == 4) begin
          settle(); chk("m0_locked", bus.locked, 1); chk("m0_mode", bus.mode_det, 0);
        end
        if (p == 15) begin
          settle();
          chk("m0_rep_cnt", bus.rep_cnt, rep + 1);
          chk("m0_done", bus.done, rep);
          chk("m0_no_err", bus.err, 0);
        end
      end
      idle(1);
    end

    // Mode 1: locks on the first sample
    for (int k = 0; k < 16; k++) begin
      drive(seqs[1][k % 8]);
      if (k == 0) begin
        settle(); chk("m1_locked", bus.locked, 1); chk("m1_mode", bus.mode_det, 1);
      end
      if (k == 15) begin
        settle(); chk("m1_done", bus.done, 1);
      end
    end
    idle(2);

    // Mode 0/2 separated by the fifth sample
    drive(8'h80); drive(8'hC0); drive(8'hE0); drive(8'hF0);
    settle(); chk("m02_unlocked", bus.locked, 0);
    drive(8'hF0);
    settle(); chk("m2_locked", bus.locked, 1); chk("m2_mode", bus.mode_det, 2);
    drive(8'hF0);
    idle(1);

    do_reset();
    drive(8'h00);
    settle(); chk("idle_junk_err", bus.err, 0); chk("idle_junk_locked", bus.locked, 0);
    idle(2);

    // Mode 3 broken at step 2 by a mode 1 step-0 value
    drive(8'h87); drive(8'hC3); drive(8'h81);
    settle();
    chk("viol_err", bus.err, 1);
    chk("viol_locked", bus.locked, 1);
    chk("viol_mode", bus.mode_det, 1);
    chk("viol_step", bus.step_idx, 0);
    chk("viol_rep", bus.rep_cnt, 0);
    idle(1);

    // Random traffic: mostly legal sequences, some mode switches, junk and resets
    cur_mode = 0;
    cur_pos  = 0;
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(99);
      if (r < 2) begin
        do_reset();
      end else begin
        if (r < 10) begin
          cur_mode = $urandom_range(3);
          cur_pos  = 0;
        end
        if (r >= 10 && r < 18) begin
          v = 8'($urandom);
        end else begin
          v = seqs[cur_mode][cur_pos];
          cur_pos = (cur_pos + 1) % lens[cur_mode];
        end
        drive(v);
        idle($urandom_range(0, 3));
      end
    end
    idle(4);
    chk("sb_drained", sb.size(), 0);

`ifdef HL_MON_TIMEOUT_EN
    begin
      int hit;
      do_reset();
      chk_quiet = 1'b0;
      hit = 0;
      drive(8'h81);
      @(posedge clk);
      for (int i = 1; i <= 30 && hit == 0; i++) begin
        @(negedge clk);
        bus.led_vld = 1'b0;
        @(posedge clk);
        #2;
        if (bus.err) hit = i;
      end
      chk("timeout_cycles", hit, 10);
      chk("timeout_unlocked", bus.locked, 0);
      chk("timeout_step", bus.step_idx, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
